program_counter: RTL and testbench

- Program-counter register for the instruction-fetch stage of the pipelined RV32IMC core.
- Registers the next-fetch address computed upstream (sequential increment, branch or jump target) on each rising clock edge.
- Drives the registered value as the instruction-memory address.
- Pure storage element: no internal increment logic; the next-address mux lives outside this block.

---
 rtl/program_counter.sv | 40 ++++
 tb/tb_program_counter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Program-counter register for the RV32IMC instruction-fetch stage.
// The next-fetch address is chosen upstream (increment, branch or jump).
// This block only captures that address, keeps it halfword aligned, and
// drives it to instruction memory straight from the register.
module program_counter #(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 12'h000
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  output logic [ADDR_WIDTH-1:0] inst_addr
);

  // Bit 0 of the reset value is cleared so the PC is always halfword
  // aligned, even if the reset address is mis-set by an integrator.
  localparam logic [ADDR_WIDTH-1:0] RESET_ALIGNED =
    {RESET_ADDR[ADDR_WIDTH-1:1], 1'b0};

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] next_pc;

  // Drop bit 0 of the incoming address; compressed instructions are
  // halfword aligned, so the LSB of a fetch address is always zero.
  always_comb begin
    next_pc = {addr_in[ADDR_WIDTH-1:1], 1'b0};
  end

  // PC register: async reset has priority, otherwise load every cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc <= RESET_ALIGNED;
    end else begin
      pc <= next_pc;
    end
  end

  assign inst_addr = pc;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios followed by
// randomized addresses and reset pulses, compared against a behavioural model.
module tb_program_counter;

  localparam int unsigned    AW      = 12;
  localparam logic [AW-1:0]  RST_LO  = 12'h000;
  localparam logic [AW-1:0]  RST_HI  = 12'h100;

  logic          clk;
  logic          nrst;
  logic [AW-1:0] addr_in;
  logic [AW-1:0] inst_addr_lo;
  logic [AW-1:0] inst_addr_hi;

  logic [AW-1:0] exp_lo;
  logic [AW-1:0] exp_hi;

  int checks;
  int errors;

  program_counter #(
    .ADDR_WIDTH(AW),
    .RESET_ADDR(RST_LO)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .addr_in  (addr_in),
    .inst_addr(inst_addr_lo)
  );

  program_counter #(
    .ADDR_WIDTH(AW),
    .RESET_ADDR(RST_HI)
  ) dut_hi (
    .clk      (clk),
    .nrst     (nrst),
    .addr_in  (addr_in),
    .inst_addr(inst_addr_hi)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the fetch address is the requested address rounded
  // down to an even byte address.
  function automatic logic [AW-1:0] aligned(input logic [AW-1:0] a);
    int unsigned v;
    v = (int'(a) / 2) * 2;
    return v[AW-1:0];
  endfunction

  task automatic check_one(input string tag, input logic [AW-1:0] obs,
                           input logic [AW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_both(input string tag);
    check_one({tag, "_lo"}, inst_addr_lo, exp_lo);
    check_one({tag, "_hi"}, inst_addr_hi, exp_hi);
  endtask

  task automatic force_reset_model();
    exp_lo = RST_LO;
    exp_hi = RST_HI;
  endtask

  // Drive addr_in just after an edge, wait for the next rising edge,
  // update the model from what was presented, then check 1 ns later.
  task automatic cycle(input logic [AW-1:0] a, input string tag);
    addr_in = a;
    @(posedge clk);
    if (nrst) begin
      exp_lo = aligned(addr_in);
      exp_hi = aligned(addr_in);
    end else begin
      force_reset_model();
    end
    #1;
    check_both(tag);
  endtask

  initial begin
    logic [AW-1:0] r;
    checks  = 0;
    errors  = 0;
    nrst    = 1'b1;
    addr_in = 12'h004;
    #1 nrst = 1'b0;
    force_reset_model();
    #1 check_both("reset_async");

    // Reset hold for 100 ns with the clock running
    repeat (10) cycle(12'h004, "reset_hold");

    // Release between edges: no change until the next rising edge
    #3 nrst = 1'b1;
    #1 check_both("release_early");
    cycle(12'h004, "release_load");

    // Sequential stream
    cycle(12'h008, "stream_008");
    cycle(12'h00C, "stream_00c");
    cycle(12'h010, "stream_010");

    // Async reset half a cycle after a load
    #4 nrst = 1'b0;
    force_reset_model();
    #1 check_both("async_mid");
    cycle(12'h004, "reset_ignore");
    #4 nrst = 1'b1;
    cycle(12'h008, "after_reset");

    // Reset coincident with a rising edge
    @(posedge clk);
    nrst = 1'b0;
    force_reset_model();
    #1 check_both("coincident");
    #4 nrst = 1'b1;

    // Alignment and width
    cycle(12'hFFF, "align_fff");
    cycle(12'h001, "align_001");

    // Randomized addresses with occasional mid-cycle reset pulses
    for (int i = 0; i < 300; i++) begin
      r = AW'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        #2 nrst = 1'b0;
        force_reset_model();
        #1 check_both("rand_reset");
        #2 nrst = 1'b1;
      end
      cycle(r, "rand_load");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
